sqrt_ctrl: RTL and testbench



---
 rtl/sqrt_pkg.sv | 53 +++++
 rtl/sqrt_ctrl_dec.sv | 57 +++++
 rtl/sqrt_ctrl.sv | 143 ++++++++++++++
 tb/tb_sqrt_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared definitions for the integer square-root controller (sqrt_ctrl).
//
// Contents:
//   - bus_ctrl bit positions (datapath control word, 10 bits)
//   - bus_proc field positions (s = [8:0], x = [16:9])
//   - sqrt_state_e, the controller state encoding
//
// Optional build macro used elsewhere in this slice: SQRT_CTRL_ITER_EN
// (adds iter_o to sqrt_ctrl).
package sqrt_pkg;

  // bus_ctrl bit positions
  localparam int CTRL_INIT     = 0;  // datapath init (s, d preset)
  localparam int CTRL_WR_S     = 1;  // s <= reg1 + reg2
  localparam int CTRL_WR_D     = 2;  // d <= reg1 + reg2
  localparam int CTRL_WR_R     = 3;  // r / dt_o <= d >> 1
  localparam int CTRL_EN_R1    = 4;  // reg1 <= selected signal
  localparam int CTRL_EN_R2    = 5;  // reg2 <= selected signal
  localparam int CTRL_SEL_D    = 6;  // select d
  localparam int CTRL_SEL_AUX2 = 7;  // select constant 2
  localparam int CTRL_SEL_S    = 8;  // select s
  localparam int CTRL_SEL_AUX1 = 9;  // select constant 1

  // bus_proc field positions
  localparam int S_LSB = 0;
  localparam int S_MSB = 8;
  localparam int X_LSB = 9;
  localparam int X_MSB = 16;

  // Iteration counter width; holds MAX_ITER values up to 31.
  localparam int ITER_W = 5;

  // Controller states. Every loop iteration walks CMP..S2_WR (10 states);
  // reads and writes sit in separate cycles so reg1/reg2 always see
  // post-write values.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_INIT  = 4'd1,
    ST_CMP   = 4'd2,
    ST_D_R1  = 4'd3,
    ST_D_R2  = 4'd4,
    ST_D_WR  = 4'd5,
    ST_S1_R1 = 4'd6,
    ST_S1_R2 = 4'd7,
    ST_S1_WR = 4'd8,
    ST_S2_R1 = 4'd9,
    ST_S2_R2 = 4'd10,
    ST_S2_WR = 4'd11,
    ST_RES   = 4'd12,
    ST_DONE  = 4'd13
  } sqrt_state_e;

endpackage

// File: rtl/sqrt_ctrl_dec.sv
// Purely combinational state -> bus_ctrl decoder for sqrt_ctrl.
//
// Ports:
//   state_i   in   sqrt_state_e   state to decode
//   ctrl_o    out  [CTRL_W-1:0]   datapath control word
//
// At most one select bit [9:6] is set for any state, and the register
// enables [5:4] only ever appear together with a select bit.
module sqrt_ctrl_dec
  import sqrt_pkg::*;
#(
  parameter int CTRL_W = 10
) (
  input  sqrt_state_e       state_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_INIT: ctrl_o[CTRL_INIT] = 1'b1;
      // d += 2
      ST_D_R1: begin
        ctrl_o[CTRL_SEL_D]  = 1'b1;
        ctrl_o[CTRL_EN_R1]  = 1'b1;
      end
      ST_D_R2: begin
        ctrl_o[CTRL_SEL_AUX2] = 1'b1;
        ctrl_o[CTRL_EN_R2]    = 1'b1;
      end
      ST_D_WR: ctrl_o[CTRL_WR_D] = 1'b1;
      // s += d
      ST_S1_R1: begin
        ctrl_o[CTRL_SEL_S]  = 1'b1;
        ctrl_o[CTRL_EN_R1]  = 1'b1;
      end
      ST_S1_R2: begin
        ctrl_o[CTRL_SEL_D]  = 1'b1;
        ctrl_o[CTRL_EN_R2]  = 1'b1;
      end
      ST_S1_WR: ctrl_o[CTRL_WR_S] = 1'b1;
      // s += 1
      ST_S2_R1: begin
        ctrl_o[CTRL_SEL_S]  = 1'b1;
        ctrl_o[CTRL_EN_R1]  = 1'b1;
      end
      ST_S2_R2: begin
        ctrl_o[CTRL_SEL_AUX1] = 1'b1;
        ctrl_o[CTRL_EN_R2]    = 1'b1;
      end
      ST_S2_WR: ctrl_o[CTRL_WR_S] = 1'b1;
      ST_RES:   ctrl_o[CTRL_WR_R] = 1'b1;
      default:  ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/sqrt_ctrl.sv
// Control FSM for the integer square-root datapath sqrt_proc.
//
// Ports:
//   clk       in   clock
//   rstn_i    in   asynchronous active-low reset
//   start_i   in   start request, sampled only in IDLE
//   bus_proc  in   [PROC_W-1:0] datapath status: s=[8:0], x=[16:9]
//   busy_o    out  low only in IDLE (datapath captures dt_i into x then)
//   bus_ctrl  out  [CTRL_W-1:0] datapath control word (see sqrt_pkg)
//   done_o    out  one-cycle completion pulse
//   err_o     out  one-cycle pulse alongside done_o when the watchdog fired
//   iter_o    out  [4:0] live iteration counter (only with SQRT_CTRL_ITER_EN)
//
// Build macro: SQRT_CTRL_ITER_EN exposes the iteration counter on iter_o;
// the counter and watchdog exist in both builds.
//
// Handshake: start_i is a level sampled on a clock edge while busy_o is
// low; that same edge moves the FSM to INIT and is the edge on which the
// datapath captures its operand. done_o marks the cycle in which dt_o is
// valid; the FSM returns to IDLE on the following edge.
//
// All outputs are registered from the next-state decode, so they line up
// with the registered state without a cycle of lag.
module sqrt_ctrl
  import sqrt_pkg::*;
#(
  parameter int MAX_ITER = 15,
  parameter int CTRL_W   = 10,
  parameter int PROC_W   = 17
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [PROC_W-1:0] bus_proc,
  output logic              busy_o,
  output logic [CTRL_W-1:0] bus_ctrl,
  output logic              done_o,
`ifdef SQRT_CTRL_ITER_EN
  output logic [ITER_W-1:0] iter_o,
`endif
  output logic              err_o
);

  localparam logic [ITER_W-1:0] MAX_ITER_V = MAX_ITER[ITER_W-1:0];

  sqrt_state_e       state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [CTRL_W-1:0] bus_ctrl_q, bus_ctrl_d;
  logic              done_q, done_d;
  logic              err_pulse_q, err_pulse_d;

  logic [8:0] s_val;
  logic [8:0] x_ext;

  assign s_val = bus_proc[S_MSB:S_LSB];
  assign x_ext = {1'b0, bus_proc[X_MSB:X_LSB]};

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_INIT;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_INIT: state_d = ST_CMP;
      ST_CMP: begin
        if (x_ext >= s_val) begin
          if (iter_q < MAX_ITER_V) begin
            state_d = ST_D_R1;
            iter_d  = iter_q + 1'b1;
          end else begin
            // Watchdog: loop would continue past the iteration limit.
            state_d = ST_RES;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_RES;
        end
      end
      ST_D_R1:  state_d = ST_D_R2;
      ST_D_R2:  state_d = ST_D_WR;
      ST_D_WR:  state_d = ST_S1_R1;
      ST_S1_R1: state_d = ST_S1_R2;
      ST_S1_R2: state_d = ST_S1_WR;
      ST_S1_WR: state_d = ST_S2_R1;
      ST_S2_R1: state_d = ST_S2_R2;
      ST_S2_R2: state_d = ST_S2_WR;
      ST_S2_WR: state_d = ST_CMP;
      ST_RES:   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  sqrt_ctrl_dec #(
    .CTRL_W (CTRL_W)
  ) u_dec (
    .state_i (state_d),
    .ctrl_o  (bus_ctrl_d)
  );

  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    err_pulse_d = (state_d == ST_DONE) && err_d;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      iter_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      bus_ctrl_q  <= '0;
      done_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      bus_ctrl_q  <= bus_ctrl_d;
      done_q      <= done_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign busy_o   = busy_q;
  assign bus_ctrl = bus_ctrl_q;
  assign done_o   = done_q;
  assign err_o    = err_pulse_q;
`ifdef SQRT_CTRL_ITER_EN
  assign iter_o   = iter_q;
`endif

endmodule

// File: tb/tb_sqrt_ctrl.sv
// Directed bench for sqrt_ctrl. Two controllers are instantiated: u_dut0
// with the default iteration limit and u_dut1 with MAX_ITER=3. Each is
// paired with a small behavioural model of the sqrt_proc datapath
// (s starts at 4, d at 2; each loop does d+=2, s+=d, s+=1; result d>>1).
module tb_sqrt_ctrl;

  logic        clk;
  logic        rstn;
  logic        start_w  [2];
  logic [7:0]  dt_w     [2];
  logic [16:0] proc_w   [2];
  logic        busy_w   [2];
  logic [9:0]  ctrl_w   [2];
  logic        done_w   [2];
  logic        err_w    [2];
  logic [4:0]  iter_w   [2];

  // datapath model state
  logic [7:0] x_m  [2];
  logic [8:0] s_m  [2];
  logic [8:0] d_m  [2];
  logic [8:0] r1_m [2];
  logic [8:0] r2_m [2];
  logic [7:0] dto_m[2];

  int n_vec;
  int n_err;
  int onehot_viol;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  sqrt_ctrl u_dut0 (
    .clk      (clk),
    .rstn_i   (rstn),
    .start_i  (start_w[0]),
    .bus_proc (proc_w[0]),
    .busy_o   (busy_w[0]),
    .bus_ctrl (ctrl_w[0]),
    .done_o   (done_w[0]),
`ifdef SQRT_CTRL_ITER_EN
    .iter_o   (iter_w[0]),
`endif
    .err_o    (err_w[0])
  );

  sqrt_ctrl #(.MAX_ITER(3)) u_dut1 (
    .clk      (clk),
    .rstn_i   (rstn),
    .start_i  (start_w[1]),
    .bus_proc (proc_w[1]),
    .busy_o   (busy_w[1]),
    .bus_ctrl (ctrl_w[1]),
    .done_o   (done_w[1]),
`ifdef SQRT_CTRL_ITER_EN
    .iter_o   (iter_w[1]),
`endif
    .err_o    (err_w[1])
  );

`ifndef SQRT_CTRL_ITER_EN
  assign iter_w[0] = '0;
  assign iter_w[1] = '0;
`endif

  assign proc_w[0] = {x_m[0], s_m[0]};
  assign proc_w[1] = {x_m[1], s_m[1]};

  // ---------------- sqrt_proc behavioural model ----------------
  function automatic logic [8:0] sel_sig(input logic [9:0] c, input logic [8:0] s,
                                         input logic [8:0] d);
    if (c[6])      return d;
    else if (c[7]) return 9'd2;
    else if (c[8]) return s;
    else if (c[9]) return 9'd1;
    else           return 9'd0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        x_m[i] <= '0; s_m[i] <= '0; d_m[i] <= '0;
        r1_m[i] <= '0; r2_m[i] <= '0; dto_m[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!busy_w[i]) x_m[i] <= dt_w[i];
        if (ctrl_w[i][0]) begin
          s_m[i] <= 9'd4;
          d_m[i] <= 9'd2;
        end
        if (ctrl_w[i][4]) r1_m[i] <= sel_sig(ctrl_w[i], s_m[i], d_m[i]);
        if (ctrl_w[i][5]) r2_m[i] <= sel_sig(ctrl_w[i], s_m[i], d_m[i]);
        if (ctrl_w[i][1]) s_m[i] <= r1_m[i] + r2_m[i];
        if (ctrl_w[i][2]) d_m[i] <= r1_m[i] + r2_m[i];
        if (ctrl_w[i][3]) dto_m[i] <= d_m[i][8:1];
      end
    end
  end

  // ---------------- select / enable invariant monitor ----------------
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 2; i++) begin
        if ($countones(ctrl_w[i][9:6]) > 1) onehot_viol++;
        if ((ctrl_w[i][5:4] != 2'b00) && (ctrl_w[i][9:6] == 4'b0000)) onehot_viol++;
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One start pulse on instance inst; waits (bounded) for done_o and
  // checks latency in edges (start edge counted as 1), result and err.
  task automatic run_op(input int inst, input logic [7:0] dt, input int exp_n,
                        input logic [7:0] exp_r, input logic exp_e, input string tag);
    int n;
    dt_w[inst]    = dt;
    start_w[inst] = 1'b1;
    tick();
    start_w[inst] = 1'b0;
    n = 1;
    while (!done_w[inst] && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_n);
    check({tag, "_result"}, dto_m[inst], exp_r);
    check({tag, "_err"}, err_w[inst], exp_e);
`ifdef SQRT_CTRL_ITER_EN
    check({tag, "_iter"}, iter_w[inst], (exp_n - 4) / 10);
`endif
    tick();
    check({tag, "_done_pulse"}, {done_w[inst], err_w[inst], busy_w[inst]}, 3'b000);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int m;
    n_vec = 0;
    n_err = 0;
    onehot_viol = 0;
    rstn = 1'b0;
    start_w[0] = 1'b0; start_w[1] = 1'b0;
    dt_w[0] = '0; dt_w[1] = '0;

    tick();
    tick();
    check("reset_outputs0", {busy_w[0], ctrl_w[0], done_w[0], err_w[0]}, 13'd0);
    check("reset_outputs1", {busy_w[1], ctrl_w[1], done_w[1], err_w[1]}, 13'd0);
    rstn = 1'b1;
    tick();

    // small operand: control sequence INIT, 0, RES, then DONE
    dt_w[0]    = 8'd3;
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    check("small_init", {busy_w[0], ctrl_w[0]}, {1'b1, 10'h001});
    tick();
    check("small_cmp", {busy_w[0], ctrl_w[0]}, {1'b1, 10'h000});
    tick();
    check("small_res", {busy_w[0], ctrl_w[0]}, {1'b1, 10'h008});
    tick();
    check("small_done", {done_w[0], err_w[0], ctrl_w[0]}, {2'b10, 10'h000});
    check("small_result", dto_m[0], 8'd1);
    tick();
    check("small_idle", {busy_w[0], done_w[0]}, 2'b00);

    run_op(0, 8'd0,   4,   8'd1,  1'b0, "x0");
    run_op(0, 8'd4,   14,  8'd2,  1'b0, "x4");
    run_op(0, 8'd15,  24,  8'd3,  1'b0, "x15");
    run_op(0, 8'd16,  34,  8'd4,  1'b0, "x16");
    run_op(0, 8'd144, 114, 8'd12, 1'b0, "x144");
    run_op(0, 8'd255, 144, 8'd15, 1'b0, "x255");

    // watchdog on the MAX_ITER=3 instance
    run_op(1, 8'd100, 34, 8'd4, 1'b1, "wdog");
    // same instance without the watchdog firing (k=2 < 3)
    run_op(1, 8'd9, 24, 8'd3, 1'b0, "wdog_ok");

    // reset mid-loop
    dt_w[0]    = 8'd200;
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("pre_reset_busy", busy_w[0], 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_reset", {busy_w[0], ctrl_w[0], done_w[0]}, 12'd0);
    tick();
    check("mid_reset_hold", {busy_w[0], ctrl_w[0], done_w[0]}, 12'd0);
    rstn = 1'b1;
    tick();
    run_op(0, 8'd200, 134, 8'd14, 1'b0, "after_reset");

    // start held high across two operations; dt_i changes while busy
    dt_w[0]    = 8'd9;
    start_w[0] = 1'b1;
    tick();
    n = 1;
    while (!done_w[0] && n < 400) begin
      tick();
      n++;
      if (n == 5)  dt_w[0] = 8'd50;
      if (n == 20) dt_w[0] = 8'd16;
    end
    check("held_first_latency", n, 24);
    check("held_first_result", dto_m[0], 8'd3);
    m = 0;
    do begin
      tick();
      m++;
      if (m == 5) start_w[0] = 1'b0;
    end while (!done_w[0] && m < 400);
    check("held_second_latency", m, 35);
    check("held_second_result", dto_m[0], 8'd4);
    tick();
    check("held_back_idle", {busy_w[0], done_w[0]}, 2'b00);

    check("select_invariant", onehot_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
